reduce_table_multi_op: RTL and testbench

//  Successor to the single-adder reduction table. Collects child contributions per tag, combines them

---
 rtl/reduce_table_multi_op_if.sv | 34 +++
 rtl/reduce_table_multi_op.sv | 195 +++++++++++++++++++
 tb/tb_reduce_table_multi_op.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reduce_table_multi_op_if.sv
// Packet-in / result-out handshake bundle for reduce_table_multi_op, plus its status outputs.
// The master side drives packets and result acceptance; the slave side is the reduction unit.
interface reduce_table_multi_op_if #(
  parameter int PayloadWidth = 64,
  parameter int HdrWidth     = 38,
  parameter int LgTableDepth = 5,
  parameter int ChildWidth   = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in_tag;
  logic [2:0]                  in_op;
  logic [ChildWidth-1:0]       in_children;
  logic [HdrWidth-1:0]         in_hdr;
  logic [PayloadWidth-1:0]     in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [7:0]                  out_tag;
  logic [2:0]                  out_op;
  logic [HdrWidth-1:0]         out_hdr;
  logic [PayloadWidth-1:0]     out_data;
  logic                        err_op;
  logic [2**LgTableDepth-1:0]  busy_map;

  modport master (
    output in_valid, in_tag, in_op, in_children, in_hdr, in_data, out_ready,
    input  in_ready, out_valid, out_tag, out_op, out_hdr, out_data, err_op, busy_map
  );

  modport slave (
    input  in_valid, in_tag, in_op, in_children, in_hdr, in_data, out_ready,
    output in_ready, out_valid, out_tag, out_op, out_hdr, out_data, err_op, busy_map
  );
endinterface

// File: rtl/reduce_table_multi_op.sv
// Per-tag reduction table: accumulates child contributions through a pipelined 8-op ALU and
// queues each finished reduction in a first-word-fall-through output FIFO.
module reduce_table_multi_op #(
  parameter int PayloadWidth = 64,
  parameter int HdrWidth     = 38,
  parameter int LgTableDepth = 5,
  parameter int ChildWidth   = 4,
  parameter int AluLatency   = 2,
  parameter int LgOutDepth   = 2
) (
  input logic                   clk,
  input logic                   rst,
  reduce_table_multi_op_if.slave bus
);
  localparam int Entries  = 2**LgTableDepth;
  localparam int OutDepth = 2**LgOutDepth;
  localparam int CntWidth = LgOutDepth + 1;
  localparam int SumWidth = CntWidth + 3;

  typedef enum logic [1:0] {ENTRY_FREE, ENTRY_ACCUM, ENTRY_BUSY} entry_state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_MAXS, OP_MINS, OP_AND, OP_OR, OP_XOR, OP_MAXU, OP_MINU
  } op_e;

  typedef struct packed {
    logic [7:0]              tag;
    logic [2:0]              op;
    logic [HdrWidth-1:0]     hdr;
    logic [PayloadWidth-1:0] data;
  } result_t;

  function automatic logic [PayloadWidth-1:0] alu(
    input op_e op, input logic [PayloadWidth-1:0] a, input logic [PayloadWidth-1:0] b
  );
    logic [PayloadWidth-1:0] r;
    r = a;
    case (op)
      OP_ADD:  r = a + b;
      OP_MAXS: r = ($signed(a) > $signed(b)) ? a : b;
      OP_MINS: r = ($signed(a) < $signed(b)) ? a : b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MAXU: r = (a > b) ? a : b;
      OP_MINU: r = (a < b) ? a : b;
    endcase
    return r;
  endfunction

  // Reduction table
  entry_state_e            state_q [Entries];
  logic [7:0]              tag_q   [Entries];
  logic [2:0]              op_q    [Entries];
  logic [HdrWidth-1:0]     hdr_q   [Entries];
  logic [PayloadWidth-1:0] acc_q   [Entries];
  logic [ChildWidth-1:0]   rem_q   [Entries];
  logic                    err_q;

  // ALU pipeline
  logic [AluLatency-1:0]   pipe_vld;
  logic [AluLatency-1:0]   pipe_fin;
  logic [LgTableDepth-1:0] pipe_idx [AluLatency];
  logic [PayloadWidth-1:0] pipe_res [AluLatency];

  // Output FIFO
  result_t                 fifo_mem [OutDepth];
  logic [LgOutDepth-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [CntWidth-1:0]     fifo_count;

  logic [LgTableDepth-1:0] idx, wb_idx;
  logic                    accept, acc_free, acc_accum, op_match;
  logic                    issue, issue_final, mismatch;
  logic                    wb, wb_fin;
  logic [PayloadWidth-1:0] wb_res, alu_res;
  logic                    push_wb, push_leaf, pop, out_valid;
  logic [1:0]              n_push;
  logic [2:0]              inflight_finals;
  logic [SumWidth-1:0]     reserved;
  result_t                 wb_rec, leaf_rec, head;

  assign idx         = bus.in_tag[LgTableDepth-1:0];
  assign accept      = bus.in_valid && bus.in_ready;
  assign acc_free    = accept && (state_q[idx] == ENTRY_FREE);
  assign acc_accum   = accept && (state_q[idx] == ENTRY_ACCUM);
  assign op_match    = (op_q[idx] == bus.in_op);
  assign issue       = acc_accum && op_match;
  assign issue_final = (rem_q[idx] == ChildWidth'(1));
  assign mismatch    = acc_accum && !op_match;
  assign alu_res     = alu(op_e'(bus.in_op), acc_q[idx], bus.in_data);

  assign wb     = pipe_vld[AluLatency-1];
  assign wb_fin = pipe_fin[AluLatency-1];
  assign wb_idx = pipe_idx[AluLatency-1];
  assign wb_res = pipe_res[AluLatency-1];

  assign push_wb    = wb && wb_fin;
  assign push_leaf  = acc_free && (bus.in_children == '0);
  assign n_push     = {1'b0, push_wb} + {1'b0, push_leaf};
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && bus.out_ready;
  assign wr_ptr_nxt = wr_ptr + LgOutDepth'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inflight_finals = '0;
    for (int s = 0; s < AluLatency; s++) begin
      inflight_finals = inflight_finals + 3'(pipe_vld[s] && pipe_fin[s]);
    end
  end

  // Results already committed to finish count against FIFO space, so a push can never overflow.
  assign reserved     = SumWidth'(fifo_count) + SumWidth'(inflight_finals);
  assign bus.in_ready = rst && (state_q[idx] != ENTRY_BUSY) && (reserved < SumWidth'(OutDepth));

  always_comb begin
    wb_rec.tag    = tag_q[wb_idx];
    wb_rec.op     = op_q[wb_idx];
    wb_rec.hdr    = hdr_q[wb_idx];
    wb_rec.data   = wb_res;
    leaf_rec.tag  = bus.in_tag;
    leaf_rec.op   = bus.in_op;
    leaf_rec.hdr  = bus.in_hdr;
    leaf_rec.data = bus.in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) state_q[i] <= ENTRY_FREE;
      err_q      <= 1'b0;
      pipe_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      err_q <= mismatch;
      if (acc_free && (bus.in_children != '0)) state_q[idx] <= ENTRY_ACCUM;
      if (issue) state_q[idx] <= ENTRY_BUSY;
      // The writeback entry is BUSY, so it can never collide with this cycle's accept.
      if (wb) state_q[wb_idx] <= wb_fin ? ENTRY_FREE : ENTRY_ACCUM;

      pipe_vld[0] <= issue;
      for (int s = 1; s < AluLatency; s++) pipe_vld[s] <= pipe_vld[s-1];

      wr_ptr     <= wr_ptr + LgOutDepth'(n_push);
      rd_ptr     <= rd_ptr + LgOutDepth'(pop);
      fifo_count <= fifo_count + CntWidth'(n_push) - CntWidth'(pop);
    end
  end

  // NOTE: payload storage has no reset; the state, valid and count registers qualify every read.
  always_ff @(posedge clk) begin
    if (acc_free) begin
      tag_q[idx] <= bus.in_tag;
      op_q[idx]  <= bus.in_op;
      hdr_q[idx] <= bus.in_hdr;
      acc_q[idx] <= bus.in_data;
      rem_q[idx] <= bus.in_children;
    end
    if (wb) begin
      acc_q[wb_idx] <= wb_res;
      rem_q[wb_idx] <= rem_q[wb_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    pipe_idx[0] <= idx;
    pipe_res[0] <= alu_res;
    pipe_fin[0] <= issue_final;
    for (int s = 1; s < AluLatency; s++) begin
      pipe_idx[s] <= pipe_idx[s-1];
      pipe_res[s] <= pipe_res[s-1];
      pipe_fin[s] <= pipe_fin[s-1];
    end
  end

  // A finishing writeback lands ahead of a leaf arriving on the same edge.
  always_ff @(posedge clk) begin
    if (push_wb) fifo_mem[wr_ptr] <= wb_rec;
    if (push_leaf) fifo_mem[push_wb ? wr_ptr_nxt : wr_ptr] <= leaf_rec;
  end

  assign head          = fifo_mem[rd_ptr];
  assign bus.out_valid = out_valid;
  assign bus.out_tag   = out_valid ? head.tag  : '0;
  assign bus.out_op    = out_valid ? head.op   : '0;
  assign bus.out_hdr   = out_valid ? head.hdr  : '0;
  assign bus.out_data  = out_valid ? head.data : '0;
  assign bus.err_op    = err_q;

  always_comb begin
    bus.busy_map = '0;
    for (int i = 0; i < Entries; i++) bus.busy_map[i] = (state_q[i] != ENTRY_FREE);
  end
endmodule

// File: tb/tb_reduce_table_multi_op.sv
// Self-checking bench for reduce_table_multi_op: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level model of the reduction table.
module tb_reduce_table_multi_op;
  localparam int PW = 64, HW = 38, LTD = 5, CW = 4, LAT = 2, LOD = 2;
  localparam int ENTRIES = 2**LTD, OUT_DEPTH = 2**LOD;
  localparam logic [2:0] OP_ADD = 3'd0, OP_MAXS = 3'd1, OP_MINS = 3'd2, OP_AND = 3'd3,
                         OP_OR = 3'd4, OP_XOR = 3'd5, OP_MAXU = 3'd6;

  typedef struct packed {
    logic [7:0]    tag;
    logic [2:0]    op;
    logic [HW-1:0] hdr;
    logic [PW-1:0] data;
  } rec_t;

  typedef struct {
    int unsigned   due;
    int            idx;
    logic [PW-1:0] res;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reduce_table_multi_op_if #(.PayloadWidth(PW), .HdrWidth(HW), .LgTableDepth(LTD), .ChildWidth(CW)) bus();

  reduce_table_multi_op #(
    .PayloadWidth(PW), .HdrWidth(HW), .LgTableDepth(LTD), .ChildWidth(CW),
    .AluLatency(LAT), .LgOutDepth(LOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit tb_rst, tb_out_ready;

  // Model: per-entry bookkeeping, pending ALU results and the output queue.
  bit            m_used [ENTRIES];
  bit            m_busy [ENTRIES];
  logic [7:0]    m_tag  [ENTRIES];
  logic [2:0]    m_op   [ENTRIES];
  logic [HW-1:0] m_hdr  [ENTRIES];
  logic [PW-1:0] m_acc  [ENTRIES];
  int            m_rem  [ENTRIES];
  bit            m_err;
  int unsigned   cyc;
  rec_t          oq[$];
  pend_t         pend[$];
  rec_t          dut_log[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] model_alu(input logic [2:0] op, input logic [PW-1:0] a,
                                               input logic [PW-1:0] b);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return (sa >= sb) ? a : b;
      3'd2:    return (sa <= sb) ? a : b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return (a >= b) ? a : b;
      default: return (a <= b) ? a : b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_used[i] = 1'b0;
      m_busy[i] = 1'b0;
      m_rem[i]  = 0;
    end
    oq.delete();
    pend.delete();
    m_err = 1'b0;
  endtask

  function automatic bit model_ready();
    int idx, finals;
    idx = int'(bus.in_tag[LTD-1:0]);
    finals = 0;
    foreach (pend[i]) if (m_rem[pend[i].idx] == 1) finals++;
    return tb_rst && !m_busy[idx] && (oq.size() + finals < OUT_DEPTH);
  endfunction

  task automatic model_edge(output bit accepted);
    int idx;
    bit nerr;
    pend_t p;
    rec_t r;
    idx = int'(bus.in_tag[LTD-1:0]);
    accepted = 1'b0;
    if (!tb_rst) begin
      model_reset();
    end else begin
      accepted = bus.in_valid && model_ready();
      nerr = 1'b0;
      if (oq.size() != 0 && tb_out_ready) void'(oq.pop_front());
      while (pend.size() != 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        m_acc[p.idx] = p.res;
        m_rem[p.idx]--;
        m_busy[p.idx] = 1'b0;
        if (m_rem[p.idx] == 0) begin
          m_used[p.idx] = 1'b0;
          r = {m_tag[p.idx], m_op[p.idx], m_hdr[p.idx], p.res};
          oq.push_back(r);
        end
      end
      if (accepted) begin
        if (!m_used[idx]) begin
          if (bus.in_children == '0) begin
            r = {bus.in_tag, bus.in_op, bus.in_hdr, bus.in_data};
            oq.push_back(r);
          end else begin
            m_used[idx] = 1'b1;
            m_tag[idx]  = bus.in_tag;
            m_op[idx]   = bus.in_op;
            m_hdr[idx]  = bus.in_hdr;
            m_acc[idx]  = bus.in_data;
            m_rem[idx]  = int'(bus.in_children);
          end
        end else if (bus.in_op == m_op[idx]) begin
          p.due = cyc + LAT;
          p.idx = idx;
          p.res = model_alu(bus.in_op, m_acc[idx], bus.in_data);
          pend.push_back(p);
          m_busy[idx] = 1'b1;
        end else begin
          nerr = 1'b1;
        end
      end
      m_err = nerr;
    end
    cyc++;
  endtask

  task automatic compare_outputs();
    rec_t exp_r, got;
    logic [ENTRIES-1:0] exp_map;
    check("in_ready", bus.in_ready, model_ready());
    check("out_valid", bus.out_valid, oq.size() != 0);
    exp_r = (oq.size() != 0) ? oq[0] : '0;
    check("out_tag", bus.out_tag, exp_r.tag);
    check("out_op", bus.out_op, exp_r.op);
    check("out_hdr", bus.out_hdr, exp_r.hdr);
    check("out_data", bus.out_data, exp_r.data);
    check("err_op", bus.err_op, m_err);
    for (int i = 0; i < ENTRIES; i++) exp_map[i] = m_used[i];
    check("busy_map", bus.busy_map, exp_map);
    if (bus.out_valid && tb_out_ready) begin
      got = {bus.out_tag, bus.out_op, bus.out_hdr, bus.out_data};
      dut_log.push_back(got);
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] tag, input logic [2:0] op,
                       input logic [CW-1:0] ch, input logic [HW-1:0] hdr,
                       input logic [PW-1:0] data, output bit accepted);
    rst             = tb_rst;
    bus.in_valid    = v;
    bus.in_tag      = tag;
    bus.in_op       = op;
    bus.in_children = ch;
    bus.in_hdr      = hdr;
    bus.in_data     = data;
    bus.out_ready   = tb_out_ready;
    #1;
    compare_outputs();
    model_edge(accepted);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 3'd0, '0, '0, '0, a);
  endtask

  task automatic send(input logic [7:0] tag, input logic [2:0] op, input logic [CW-1:0] ch,
                      input logic [HW-1:0] hdr, input logic [PW-1:0] data, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    while (!acc && waits < 40) begin
      cycle(1'b1, tag, op, ch, hdr, data, acc);
      if (!acc) waits++;
    end
    check("send_accept", acc, 1'b1);
  endtask

  function automatic logic [PW-1:0] find_data(input logic [7:0] tag);
    logic [PW-1:0] d;
    d = 64'hDEAD_BEEF_DEAD_BEEF;
    foreach (dut_log[i]) if (dut_log[i].tag == tag) d = dut_log[i].data;
    return d;
  endfunction

  function automatic int count_tag(input logic [7:0] tag);
    int n;
    n = 0;
    foreach (dut_log[i]) if (dut_log[i].tag == tag) n++;
    return n;
  endfunction

  function automatic logic [PW-1:0] rand_data();
    case ($urandom_range(0, 4))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, n_acc;
    bit a;
    logic [7:0] tg, t;
    logic [2:0] op;
    logic [HW-1:0] h;

    h = 38'h12_3456_789A;
    tb_rst = 1'b0;
    tb_out_ready = 1'b1;
    cyc = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_tag = '0;
    bus.in_op = '0;
    bus.in_children = '0;
    bus.in_hdr = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_busy_map", bus.busy_map, 32'd0);
    tb_rst = 1'b1;
    idle(2);

    // Leaf
    dut_log.delete();
    send(8'd3, OP_ADD, 4'd0, h, 64'd7, w);
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_out_data", bus.out_data, 64'd7);
    check("t1_out_tag", bus.out_tag, 8'd3);
    idle(3);

    // ADD with wrap
    dut_log.delete();
    send(8'd5, OP_ADD, 4'd2, h, 64'd5, w);
    send(8'd5, OP_ADD, 4'd0, 38'd0, 64'd10, w);
    send(8'd5, OP_ADD, 4'd0, 38'd0, 64'hFFFF_FFFF_FFFF_FFFF, w);
    idle(LAT + 3);
    check("t2_sum", find_data(8'd5), 64'd14);
    check("t2_count", count_tag(8'd5), 1);

    // Interleaved MINS / MAXU
    dut_log.delete();
    send(8'd1, OP_MINS, 4'd2, h, 64'hFFFF_FFFF_FFFF_FFFC, w);
    send(8'd2, OP_MAXU, 4'd1, h, 64'd1, w);
    send(8'd1, OP_MINS, 4'd0, h, 64'd9, w);
    send(8'd2, OP_MAXU, 4'd0, h, 64'h8000_0000_0000_0000, w);
    send(8'd1, OP_MINS, 4'd0, h, 64'hFFFF_FFFF_FFFF_FFEC, w);
    idle(LAT + 3);
    check("t3_mins", find_data(8'd1), 64'hFFFF_FFFF_FFFF_FFEC);
    check("t3_maxu", find_data(8'd2), 64'h8000_0000_0000_0000);

    // Back-to-back AND on one tag stalls while the entry is busy
    dut_log.delete();
    send(8'd7, OP_AND, 4'd2, h, 64'hFF0F, w);
    send(8'd7, OP_AND, 4'd0, h, 64'h0FFF, w);
    send(8'd7, OP_AND, 4'd0, h, 64'h00F3, w);
    check("t4_stall", w, LAT);
    idle(LAT + 3);
    check("t4_and", find_data(8'd7), 64'h0003);

    // FIFO fill with consumer stalled, then drain in order
    tb_out_ready = 1'b0;
    for (int i = 0; i < OUT_DEPTH; i++) send(8'(10 + i), OP_OR, 4'd0, h, 64'(3 * i), w);
    check("t5_full_ready", bus.in_ready, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'd14, OP_OR, 4'd0, h, 64'd99, a);
      if (a) n_acc++;
    end
    check("t5_held", n_acc, 0);
    tb_out_ready = 1'b1;
    dut_log.delete();
    send(8'd14, OP_OR, 4'd0, h, 64'd99, w);
    idle(OUT_DEPTH + 3);
    check("t5_count", dut_log.size(), OUT_DEPTH + 1);
    for (int i = 0; i <= OUT_DEPTH; i++) begin
      t = (i < dut_log.size()) ? dut_log[i].tag : 8'hFF;
      check("t5_order", t, 8'(10 + i));
    end

    // Op mismatch drops the packet and pulses err_op
    dut_log.delete();
    send(8'd20, OP_ADD, 4'd1, h, 64'd100, w);
    send(8'd20, OP_XOR, 4'd0, h, 64'd5, w);
    check("t6_err", bus.err_op, 1'b1);
    send(8'd20, OP_ADD, 4'd0, h, 64'd23, w);
    idle(LAT + 3);
    check("t6_sum", find_data(8'd20), 64'd123);

    // Reset while a combine is in flight discards it
    dut_log.delete();
    send(8'd21, OP_ADD, 4'd1, h, 64'd1, w);
    send(8'd21, OP_ADD, 4'd0, h, 64'd2, w);
    tb_rst = 1'b0;
    idle(1);
    tb_rst = 1'b1;
    check("t6_rst_valid", bus.out_valid, 1'b0);
    check("t6_rst_map", bus.busy_map, 32'd0);
    check("t6_rst_data", bus.out_data, 64'd0);
    check("t6_rst_err", bus.err_op, 1'b0);
    idle(LAT + 3);
    check("t6_rst_discard", count_tag(8'd21), 0);

    // Randomized traffic on a few aliased entries
    for (int n = 0; n < 3000; n++) begin
      tg[4:0] = 5'($urandom_range(0, 7));
      tg[7:5] = 3'($urandom_range(0, 7));
      if (m_used[tg[4:0]] && $urandom_range(0, 9) < 8) op = m_op[tg[4:0]];
      else op = 3'($urandom_range(0, 7));
      tb_out_ready = ($urandom_range(0, 3) != 0);
      tb_rst = ($urandom_range(0, 699) != 0);
      cycle($urandom_range(0, 2) != 0, tg, op, 4'($urandom_range(0, 3)),
            38'({$urandom(), $urandom()}), rand_data(), a);
    end
    tb_rst = 1'b1;
    tb_out_ready = 1'b1;
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
